// File: rtl/trace_checker.sv
// Commit-trace checker: buffers retiring register writes from the core and
// compares them in order against a golden trace, reporting sticky pass/fail.
module trace_checker #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] END_PC     = 32'h1c00_0100
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        chk_en,
  input  logic [31:0] debug_wb_pc,
  input  logic [3:0]  debug_wb_rf_we,
  input  logic [4:0]  debug_wb_rf_wnum,
  input  logic [31:0] debug_wb_rf_wdata,
  input  logic        ref_valid,
  input  logic [31:0] ref_pc,
  input  logic [4:0]  ref_wnum,
  input  logic [31:0] ref_wdata,
  output logic        ref_ready,
  output logic        pass,
  output logic        fail,
  output logic        overflow,
  output logic [31:0] err_pc,
  output logic [31:0] err_wdata,
  output logic [31:0] match_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PASS = 2'd2;
  localparam logic [1:0] S_FAIL = 2'd3;

  logic [1:0]  state;
  logic [31:0] f_pc    [FIFO_DEPTH];
  logic [3:0]  f_we    [FIFO_DEPTH];
  logic [4:0]  f_wnum  [FIFO_DEPTH];
  logic [31:0] f_wdata [FIFO_DEPTH];

  // Extra MSB on each pointer distinguishes full from empty.
  logic [AW:0] wr_ptr, rd_ptr;
  logic [AW:0] ptr_one;
  assign ptr_one = {{AW{1'b0}}, 1'b1};

  logic run, push, empty, full;
  logic [31:0] head_pc, head_wdata, byte_mask;
  logic [3:0]  head_we;
  logic [4:0]  head_wnum;
  logic        hit, mismatch, end_hit, ovf;

  assign run   = (state == S_RUN);
  assign push  = run && (debug_wb_rf_we != 4'd0) && (debug_wb_rf_wnum != 5'd0);
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign ref_ready = resetn && run && !empty && ref_valid;

  assign head_pc    = f_pc[rd_ptr[AW-1:0]];
  assign head_we    = f_we[rd_ptr[AW-1:0]];
  assign head_wnum  = f_wnum[rd_ptr[AW-1:0]];
  assign head_wdata = f_wdata[rd_ptr[AW-1:0]];
  assign byte_mask  = {{8{head_we[3]}}, {8{head_we[2]}}, {8{head_we[1]}}, {8{head_we[0]}}};

  assign hit      = (head_pc == ref_pc) && (head_wnum == ref_wnum) &&
                    (((head_wdata ^ ref_wdata) & byte_mask) == 32'd0);
  assign mismatch = ref_ready && !hit;
  assign end_hit  = ref_ready && hit && (head_pc == END_PC);
  // A pop in the same cycle frees the slot, so a full FIFO only overflows without one.
  assign ovf      = push && full && !ref_ready;

  // Storage needs no reset; occupancy is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (push && !ovf) begin
      f_pc[wr_ptr[AW-1:0]]    <= debug_wb_pc;
      f_we[wr_ptr[AW-1:0]]    <= debug_wb_rf_we;
      f_wnum[wr_ptr[AW-1:0]]  <= debug_wb_rf_wnum;
      f_wdata[wr_ptr[AW-1:0]] <= debug_wb_rf_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      overflow  <= 1'b0;
      err_pc    <= 32'd0;
      err_wdata <= 32'd0;
      match_cnt <= 32'd0;
    end else begin
      case (state)
        S_IDLE: if (chk_en) state <= S_RUN;
        S_RUN: begin
          if (push && !ovf) wr_ptr <= wr_ptr + ptr_one;
          if (ref_ready) begin
            rd_ptr <= rd_ptr + ptr_one;
            if (hit) match_cnt <= match_cnt + 32'd1;
          end
          if (mismatch || ovf) begin
            state    <= S_FAIL;
            fail     <= 1'b1;
            overflow <= ovf;
            // The compared entry takes precedence over the dropped commit.
            err_pc    <= mismatch ? head_pc    : debug_wb_pc;
            err_wdata <= mismatch ? head_wdata : debug_wb_rf_wdata;
          end else if (end_hit) begin
            state <= S_PASS;
            pass  <= 1'b1;
          end else if (!chk_en) begin
            state  <= S_IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/trace_checker.md
TRACE_CHECKER -- requirements
Module: trace_checker

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, number of buffered commit entries (power of two, >= 2).
REQ-002 Parameter: END_PC, default 32'h1c00_0100, PC whose matched commit ends the run with PASS.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 chk_en  input  1  level enable; low holds the checker in IDLE.
REQ-006 debug_wb_pc  input  32  PC of instruction retiring in the core's WB stage.
REQ-007 debug_wb_rf_we  input  4  byte write enables of the retiring register write.
REQ-008 debug_wb_rf_wnum  input  5  destination register number.
REQ-009 debug_wb_rf_wdata  input  32  register write data.
REQ-010 ref_valid  input  1  golden trace entry available.
REQ-011 ref_pc  input  32  golden PC.
REQ-012 ref_wnum  input  5  golden destination register.
REQ-013 ref_wdata  input  32  golden write data.
REQ-014 ref_ready  output  1  golden entry consumed this cycle.
REQ-015 pass  output  1  sticky, END_PC commit matched.
REQ-016 fail  output  1  sticky, mismatch or overflow detected.
REQ-017 overflow  output  1  sticky, failure cause was FIFO overflow.
REQ-018 err_pc  output  32  core PC of the failing entry.
REQ-019 err_wdata  output  32  core write data of the failing entry.
REQ-020 match_cnt  output  32  count of matched commits.

Function
REQ-021 Commit event: state RUN, debug_wb_rf_we != 0 and debug_wb_rf_wnum != 0; every other cycle is ignored.
REQ-022 Each commit event pushes {pc, we, wnum, wdata} into a FIFO_DEPTH-entry FIFO in the same cycle.
REQ-023 ref_ready = (state == RUN) && FIFO non-empty && ref_valid, combinational.
REQ-024 On ref_ready the head entry pops and is compared: pc equal, wnum equal, and wdata equal on every byte whose we bit is set; bytes with we bit clear are not compared.
REQ-025 Match: match_cnt increments by 1 (wraps 32'hFFFF_FFFF -> 0) in the next cycle; if entry pc == END_PC, state -> PASS and pass = 1 in the next cycle.
REQ-026 Mismatch: state -> FAIL, fail = 1, err_pc/err_wdata latched from the popped entry, all in the next cycle.
REQ-027 Simultaneous push and pop: allowed at any occupancy including full; occupancy unchanged.
REQ-028 Push with FIFO full and no pop that cycle: state -> FAIL, fail = 1, overflow = 1, err_pc/err_wdata = the dropped commit, next cycle.
REQ-029 Mismatch and overflow in the same cycle: mismatch entry is reported in err_pc/err_wdata; overflow = 1 also.
REQ-030 States: IDLE (chk_en = 0) -> RUN when chk_en = 1; RUN -> PASS / FAIL per REQ-025/026/028; PASS and FAIL are terminal until reset; chk_en falling in RUN -> IDLE and flushes FIFO; chk_en ignored in PASS/FAIL.
REQ-031 In IDLE, PASS and FAIL: no pushes, ref_ready = 0, match_cnt frozen.
REQ-032 FIFO pointers wrap modulo FIFO_DEPTH; empty/full from one extra pointer bit.

Reset
REQ-033 resetn low at a clock edge: state = IDLE, FIFO empty, pass = fail = overflow = 0, err_pc = err_wdata = 0, match_cnt = 0; ref_ready = 0 during reset.
REQ-034 Reset mid-run discards buffered entries; no commit or golden handshake sampled in the reset cycle.

Verification
REQ-035 chk_en = 1; commits pc 1c000000/1c000004 r4 we=F wdata 1,2; golden identical, ref_valid = 1 -> match_cnt = 2, fail = 0.
REQ-036 Commit we = 4'b0011 wdata 0000_1234, golden wdata FFFF_1234, same pc/wnum -> match (upper bytes ignored).
REQ-037 Commit pc 1c000008 r5 wdata 7, golden wdata 8 -> next cycle fail = 1, err_pc = 1c000008, err_wdata = 7, overflow = 0; later commits ignored.
REQ-038 ref_valid = 0, five consecutive commits with FIFO_DEPTH = 4 -> fifth cycle +1: fail = 1, overflow = 1, err_pc = fifth commit pc.
REQ-039 Matched commit pc = 1c000100 -> pass = 1 next cycle, ref_ready = 0 thereafter; commit with wnum = 0 or we = 0 never pushed.
REQ-040 resetn low for one cycle while FIFO holds 3 entries -> all outputs 0, FIFO empty, IDLE.
